// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed byte image into instruction memory,
// packing STEP little-endian bytes per word and halting the core while it loads.
module program_loader #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        pgm,
  output logic [INSTR_ADDR_WIDTH-1:0] addr,
  output logic [STEP*8-1:0]           data,
  output logic                        busy,
  output logic                        cpu_halt,
  output logic                        done,
  output logic                        err,
  output logic [INSTR_ADDR_WIDTH:0]   words_written
);
  localparam int CW = STEP > 1 ? $clog2(STEP) : 1;
  localparam int LW = INSTR_ADDR_WIDTH + 1 > 17 ? INSTR_ADDR_WIDTH + 1 : 17;
  localparam logic [LW-1:0] SIZE = LW'(1) << INSTR_ADDR_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(STEP - 1);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, FIN} state_t;
  state_t r_state;
  logic [15:0] r_len;
  logic [CW-1:0] r_cnt;
  logic w_xfer;
  logic [15:0] w_len_hdr;
  logic [INSTR_ADDR_WIDTH:0] w_ww_next;
  logic w_last_word;
  assign w_xfer = in_valid & in_ready;
  assign w_len_hdr = {in_data, r_len[7:0]};
  assign w_ww_next = words_written + (INSTR_ADDR_WIDTH + 1)'(1);
  assign w_last_word = LW'(w_ww_next) == LW'(r_len);
  // Handshake and status flags decode straight from the state register.
  assign in_ready = r_state inside {HDR0, HDR1, DATA};
  assign pgm = r_state == WRITE;
  assign busy = r_state != IDLE;
  assign cpu_halt = busy;
  assign done = r_state == FIN;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len <= '0;
      r_cnt <= '0;
      addr <= '0;
      data <= '0;
      err <= 1'b0;
      words_written <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= HDR0;
          err <= 1'b0;
          words_written <= '0;
          addr <= '0;
          r_cnt <= '0;
        end
        HDR0: if (w_xfer) begin
          r_len[7:0] <= in_data;
          r_state <= HDR1;
        end
        HDR1: if (w_xfer) begin
          r_len[15:8] <= in_data;
          if (w_len_hdr == 16'd0) r_state <= FIN;
          else if (LW'(w_len_hdr) > SIZE) begin
            err <= 1'b1;
            r_state <= IDLE;
          end else r_state <= DATA;
        end
        DATA: if (w_xfer) begin
          data[{r_cnt, 3'b000} +: 8] <= in_data;
          r_cnt <= r_cnt == LAST ? '0 : r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= WRITE;
        end
        WRITE: begin
          addr <= addr + INSTR_ADDR_WIDTH'(1);
          words_written <= w_ww_next;
          r_state <= w_last_word ? FIN : DATA;
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scenarios for program_loader with a 32-word memory.
module tb_program_loader;
  logic clk, rst, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, pgm, busy, cpu_halt, done, err;
  logic [4:0] addr;
  logic [31:0] data;
  logic [5:0] words_written;
  int checks = 0, passes = 0;
  int pgm_cnt = 0, done_cnt = 0, bad_ready = 0;
  logic [4:0] pg_addr[256];
  logic [31:0] pg_data[256];

  program_loader #(.INSTR_ADDR_WIDTH(5), .STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pgm(pgm), .addr(addr), .data(data), .busy(busy),
    .cpu_halt(cpu_halt), .done(done), .err(err), .words_written(words_written));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pgm) begin
      if (pgm_cnt < 256) begin
        pg_addr[pgm_cnt] = addr;
        pg_data[pgm_cnt] = data;
      end
      pgm_cnt++;
      if (in_ready) bad_ready++;
    end
    if (done) done_cnt++;
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_data = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected=1", b, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) $display("FAIL done_timeout done=%b expected=1", done); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; in_valid = 0; in_data = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    checks++; if ({busy, cpu_halt, in_ready, pgm, done, err} !== 6'b0) $display("FAIL reset_flags got=%b expected=000000", {busy, cpu_halt, in_ready, pgm, done, err}); else passes++;
    checks++; if (addr !== 5'd0 || data !== 32'd0) $display("FAIL reset_addr_data got=%h/%h expected=0/0", addr, data); else passes++;
    checks++; if (words_written !== 6'd0) $display("FAIL reset_ww got=%0d expected=0", words_written); else passes++;
  endtask

  task automatic run_basic(input string name, input int use_gaps);
    logic [7:0] v[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    int g[10] = '{0, 2, 1, 3, 0, 1, 2, 0, 4, 1};
    int base = pgm_cnt, d0 = done_cnt, br = bad_ready;
    pulse_start();
    checks++; if (busy !== 1'b1 || cpu_halt !== 1'b1) $display("FAIL %s_busy got=%b%b expected=11", name, busy, cpu_halt); else passes++;
    for (int i = 0; i < 10; i++) begin
      send(v[i], use_gaps ? g[i] : 0);
      if (i == 5) begin
        checks++; if ({pgm, in_ready} !== 2'b10 || addr !== 5'd0 || data !== 32'h00100513) $display("FAIL %s_first_pgm got=pgm%b rdy%b a%0d d%h expected=pgm1 rdy0 a0 d00100513", name, pgm, in_ready, addr, data); else passes++;
      end
    end
    in_valid = 0;
    checks++; if (busy !== 1'b1) $display("FAIL %s_busy_mid got=%b expected=1", name, busy); else passes++;
    wait_done();
    checks++; if (pgm_cnt - base !== 2) $display("FAIL %s_pgm_count got=%0d expected=2", name, pgm_cnt - base); else passes++;
    checks++; if (pg_addr[base] !== 5'd0 || pg_data[base] !== 32'h00100513) $display("FAIL %s_word0 got=%0d/%h expected=0/00100513", name, pg_addr[base], pg_data[base]); else passes++;
    checks++; if (pg_addr[base+1] !== 5'd1 || pg_data[base+1] !== 32'h00200593) $display("FAIL %s_word1 got=%0d/%h expected=1/00200593", name, pg_addr[base+1], pg_data[base+1]); else passes++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL %s_done_count got=%0d expected=1", name, done_cnt - d0); else passes++;
    checks++; if (words_written !== 6'd2 || busy !== 1'b0 || cpu_halt !== 1'b0) $display("FAIL %s_end got=ww%0d busy%b halt%b expected=ww2 busy0 halt0", name, words_written, busy, cpu_halt); else passes++;
    checks++; if (bad_ready - br !== 0) $display("FAIL %s_ready_in_pgm got=%0d expected=0", name, bad_ready - br); else passes++;
  endtask

  task automatic test_basic_load(); run_basic("basic", 0); endtask
  task automatic test_back_to_back_stall(); run_basic("stall", 1); endtask

  task automatic test_zero_len();
    int base = pgm_cnt, d0 = done_cnt;
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 0;
    checks++; if (done !== 1'b1) $display("FAIL zero_done_latency got=%b expected=1", done); else passes++;
    wait_done();
    checks++; if (pgm_cnt - base !== 0 || done_cnt - d0 !== 1) $display("FAIL zero_counts got=pgm%0d done%0d expected=pgm0 done1", pgm_cnt - base, done_cnt - d0); else passes++;
    checks++; if (words_written !== 6'd0) $display("FAIL zero_ww got=%0d expected=0", words_written); else passes++;
  endtask

  task automatic test_oversize();
    int base = pgm_cnt, d0 = done_cnt;
    pulse_start();
    send(8'h21, 0);
    send(8'h00, 0);
    in_valid = 0;
    checks++; if ({err, busy, in_ready} !== 3'b100) $display("FAIL over_err got=err%b busy%b rdy%b expected=err1 busy0 rdy0", err, busy, in_ready); else passes++;
    in_valid = 1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || err !== 1'b1) $display("FAIL over_idle got=rdy%b err%b expected=rdy0 err1", in_ready, err); else passes++;
    in_valid = 0;
    checks++; if (pgm_cnt - base !== 0 || done_cnt - d0 !== 0) $display("FAIL over_counts got=pgm%0d done%0d expected=0/0", pgm_cnt - base, done_cnt - d0); else passes++;
    pulse_start();
    checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL over_restart got=err%b busy%b expected=err0 busy1", err, busy); else passes++;
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 0;
    wait_done();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v[8] = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [7:0] w[6] = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    int base = pgm_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) send(v[i], 0);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if ({busy, cpu_halt, in_ready, pgm, done, err} !== 6'b0 || addr !== 5'd0 || data !== 32'd0 || words_written !== 6'd0) $display("FAIL rstmid_outputs got=%b a%0d d%h ww%0d expected=000000 a0 d0 ww0", {busy, cpu_halt, in_ready, pgm, done, err}, addr, data, words_written); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (pgm_cnt - base !== 1 || pg_data[base] !== 32'hDDCCBBAA || pg_addr[base] !== 5'd0) $display("FAIL rstmid_writes got=n%0d d%h a%0d expected=n1 dDDCCBBAA a0", pgm_cnt - base, pg_data[base], pg_addr[base]); else passes++;
    pulse_start();
    for (int i = 0; i < 6; i++) send(w[i], 0);
    in_valid = 0;
    wait_done();
    checks++; if (pgm_cnt - base !== 2 || pg_addr[base+1] !== 5'd0 || pg_data[base+1] !== 32'h04030201) $display("FAIL rstmid_fresh got=n%0d a%0d d%h expected=n2 a0 d04030201", pgm_cnt - base, pg_addr[base+1], pg_data[base+1]); else passes++;
  endtask

  task automatic test_full_memory();
    int base = pgm_cnt, d0 = done_cnt, bad = 0;
    logic [31:0] exp;
    pulse_start();
    send(8'h20, 0);
    send(8'h00, 0);
    for (int i = 0; i < 128; i++) send(8'(i), 0);
    in_valid = 0;
    wait_done();
    checks++; if (pgm_cnt - base !== 32) $display("FAIL full_pgm_count got=%0d expected=32", pgm_cnt - base); else passes++;
    for (int w = 0; w < 32; w++) begin
      exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      if (pg_addr[base+w] !== 5'(w) || pg_data[base+w] !== exp) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL full_words got=%0d_bad_words expected=0", bad); else passes++;
    checks++; if (done_cnt - d0 !== 1 || words_written !== 6'd32) $display("FAIL full_done got=done%0d ww%0d expected=done1 ww32", done_cnt - d0, words_written); else passes++;
    checks++; if (addr !== 5'd0) $display("FAIL full_addr_wrap got=%0d expected=0", addr); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_oversize();
    test_back_to_back_stall();
    test_reset_mid();
    test_full_memory();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
